lsu: RTL and testbench
======================

# lsu

Load/store unit sitting between the core's execute stage and the word-wide data `ram`. It accepts one byte/halfword/word load or store request at a time and issues word-aligned accesses to the memory. Sub-word stores are done as read-modify-write, because the memory only writes full words. Load data is extracted and sign/zero-extended, and completion is reported with a one-cycle valid pulse.

## Interface
- `ADDR_WIDTH`, default 32: byte-address width, shared with `ram`.

- `i_clk` in 1: clock; all state changes on posedge.
- `i_rst_n` in 1: reset; asynchronous, active-low.
- `i_req` in 1: request valid.
- `o_ready` in/out: out 1; unit idle, so a request is accepted when `i_req && o_ready`.
- `i_we` in 1: 1 = store, 0 = load.
- `i_funct3` in 3: RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `i_addr` in `ADDR_WIDTH`: byte address.
- `i_wdata` in 32: store data, taken from the low-order bytes.
- `o_rdata` out 32: extended load result, registered.
- `o_valid` out 1: one-cycle completion pulse.
- `o_fault` out 1: valid only with `o_valid`; misaligned address or illegal `funct3`.
- `o_mem_we` out 1: memory write enable.
- `o_mem_addr` out `ADDR_WIDTH`: word-aligned byte address, with [1:0] = 0.
- `o_mem_wdata` out 32: memory write data.
- `i_mem_rdata` in 32: memory read data, combinational from `o_mem_addr`.

## Operation
- Byte order is little-endian: byte offset k occupies bits [8k+7:8k].
- On accept, latch `i_we`, `i_funct3`, `i_addr` and `i_wdata`.
- FSM states: IDLE, LOAD, RMW_RD, STORE, DONE, FAULT.
- IDLE: `o_ready`=1. On accept, go to:
  - FAULT on a fault;
  - LOAD for a load;
  - STORE for SW;
  - RMW_RD for SB/SH.
- LOAD: capture `i_mem_rdata`, extract the lane, extend into `o_rdata`, then go to DONE.
- RMW_RD: capture `i_mem_rdata` and replace the addressed byte or halfword with `i_wdata`[7:0] or [15:0], then go to STORE.
- STORE: `o_mem_we`=1 with the merged or full word, then go to DONE.
- DONE: `o_valid`=1, `o_fault`=0, then go to IDLE.
- FAULT: `o_valid`=1, `o_fault`=1, no memory write, then go to IDLE.
- `o_ready`=1 only in IDLE.
  - `i_req` in any other state is ignored; the requester holds it.
- `o_mem_we` is decoded from state (STORE only), so it is never asserted outside STORE.
- Stores leave `o_rdata` unchanged. A fault leaves `o_rdata` unchanged.
- Fault conditions:
  - H/HU with addr[0]=1;
  - W with addr[1:0]≠0;
  - load `funct3` of 011, 110 or 111;
  - store `funct3` other than 000, 001 or 010.

## Timing
- Request accepted at edge N.
- Response (`o_valid` high) is in cycle:
  - N+2 for loads and SW;
  - N+3 for SB/SH, with `o_mem_we` high in cycle N+2 only;
  - N+1 for faults.
- Next accept is possible at the first edge after the `o_valid` cycle.
- Reset values: state IDLE, `o_ready`=1, `o_valid`=0, `o_fault`=0, `o_rdata`=0, `o_mem_we`=0, `o_mem_addr`=0, `o_mem_wdata`=0.
- Reset mid-operation: return to IDLE immediately and drop `o_mem_we` combinationally. No partial write ever reaches memory, and no `o_valid` is issued for the aborted request.

## Configuration
- `LSU_FAULT_EN` defined: fault checking as above.
- `LSU_FAULT_EN` undefined:
  - `o_fault` tied 0 and the FAULT state is removed;
  - halfword offset is taken from addr[1] only, and words ignore addr[1:0];
  - illegal `funct3` is treated as W.

## Structure
- Package `lsu_pkg` holds:
  - `funct3` constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the FSM state typedef/encoding.
- Sub-module `lsu_lane` (combinational) holds load extraction/extension and store byte/half merge. It is shared by the LOAD and RMW_RD paths.

## Test plan
Preload the word at 0x10 with 0x8899AABB.
- LW 0x10 accepted at N -> `o_valid` at N+2, `o_rdata`=0x8899AABB, `o_mem_we` never high.
- LB 0x11 -> 0xFFFFFFAA; LBU 0x11 -> 0x000000AA; LH 0x12 -> 0xFFFF8899; LHU 0x12 -> 0x00008899.
- SB 0x13, `i_wdata`=0x12345677 -> `o_mem_we` high only at N+2, `o_mem_addr`=0x10, word becomes 0x7799AABB, `o_valid` at N+3.
- With `LSU_FAULT_EN`, SH 0x11 -> `o_valid`=`o_fault`=1 at N+1, no write, word unchanged.
- `i_rst_n` pulsed low during RMW_RD of SB 0x10 -> `o_mem_we` never high, `o_ready`=1, word unchanged.
- Second request held during busy -> accepted only at the edge after the first `o_valid`; both complete in order with correct data.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, FSM state encoding and funct3 legality check for the lsu.
// Macro LSU_FAULT_EN adds the FAULT state.
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
`ifdef LSU_FAULT_EN
    DONE,
    FAULT
`else
    DONE
`endif
  } state_t;
  function automatic logic legal_f3(input logic we, input logic [2:0] f3);
    return we ? (f3 == F3_B || f3 == F3_H || f3 == F3_W) : !(f3 == 3'b011 || f3[2:1] == 2'b11);
  endfunction
endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: load lane extract/extend and store byte/half merge (combinational).
// Ports: f3 width code, off byte offset, word memory word,
//        wdata store data, ldata extended load result, mdata merged store word.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);
  logic [4:0]  sh;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    sh = {off, 3'b000};
    b = word[sh +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    ldata = f3 == F3_B  ? {{24{b[7]}}, b} :
            f3 == F3_BU ? {24'h0, b} :
            f3 == F3_H  ? {{16{h[15]}}, h} :
            f3 == F3_HU ? {16'h0, h} : word;
    mdata = f3 == F3_B ? (word & ~(32'hFF << sh)) | ({24'h0, wdata[7:0]} << sh) :
            f3 == F3_H ? (off[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]}) : wdata;
  end
endmodule

// File: rtl/lsu.sv
// lsu: single-request byte/half/word load-store unit over a word-wide memory.
// Ports: i_clk, i_rst_n (async low); request i_req/o_ready, i_we, i_funct3, i_addr, i_wdata;
//        response o_rdata, o_valid, o_fault; memory o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata.
// Macro LSU_FAULT_EN enables misalignment/illegal-funct3 faults; otherwise o_fault is 0.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata,
  output logic                  o_valid,
  output logic                  o_fault,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  input  logic [31:0]           i_mem_rdata
);
  state_t      state;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic [2:0]  eff_f3;
  logic [1:0]  eff_off;
  logic        fault;
  logic [31:0] ldata;
  logic [31:0] mdata;
  // Illegal codes fall back to W; halfwords only honour addr[1].
  always_comb begin
    eff_f3 = legal_f3(i_we, i_funct3) ? i_funct3 : F3_W;
    eff_off = eff_f3[1:0] == 2'b01 ? {i_addr[1], 1'b0} : i_addr[1:0];
`ifdef LSU_FAULT_EN
    fault = !legal_f3(i_we, i_funct3) ||
            (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
            (i_funct3 == F3_W && i_addr[1:0] != 2'b00);
`else
    fault = 1'b0;
`endif
  end
  // The merge reads the latched store data back from o_mem_wdata.
  lsu_lane u_lane (
    .f3   (f3),
    .off  (off),
    .word (i_mem_rdata),
    .wdata(o_mem_wdata),
    .ldata(ldata),
    .mdata(mdata)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      f3 <= '0;
      off <= '0;
      o_rdata <= '0;
      o_mem_addr <= '0;
      o_mem_wdata <= '0;
    end else
      case (state)
        IDLE:
          if (i_req) begin
            f3 <= eff_f3;
            off <= eff_off;
            o_mem_addr <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            o_mem_wdata <= i_wdata;
`ifdef LSU_FAULT_EN
            state <= fault ? FAULT : !i_we ? LOAD : eff_f3 == F3_W ? STORE : RMW_RD;
`else
            state <= fault ? DONE : !i_we ? LOAD : eff_f3 == F3_W ? STORE : RMW_RD;
`endif
          end
        LOAD: begin
          o_rdata <= ldata;
          state <= DONE;
        end
        RMW_RD: begin
          o_mem_wdata <= mdata;
          state <= STORE;
        end
        STORE: state <= DONE;
        default: state <= IDLE;
      endcase
  assign o_ready = state == IDLE;
  assign o_mem_we = state == STORE;
`ifdef LSU_FAULT_EN
  assign o_valid = state == DONE || state == FAULT;
  assign o_fault = state == FAULT;
`else
  assign o_valid = state == DONE;
  assign o_fault = 1'b0;
`endif
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed self-checking bench for lsu against a word-wide memory model.
module tb_lsu;
  logic        i_clk, i_rst_n, i_req, o_ready, i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata, o_rdata;
  logic        o_valid, o_fault, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [31:0] mem [0:63];
  int vec = 0, miss = 0;
  int lat, we_cnt, we_at;
  logic [31:0] we_addr;
  logic we_seen, v_seen;

  lsu #(.ADDR_WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_ready(o_ready), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_valid(o_valid), .o_fault(o_fault), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  assign i_mem_rdata = mem[o_mem_addr[7:2]];
  always @(posedge i_clk) if (o_mem_we) mem[o_mem_addr[7:2]] <= o_mem_wdata;

  initial i_clk = 0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request; return latency (cycle offset of o_valid, 0 = timeout) and write activity.
  task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    @(negedge i_clk);
    chk("ready_before_req", {31'b0, o_ready}, 32'd1);
    i_req = 1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
    @(posedge i_clk);
    @(negedge i_clk);
    i_req = 0;
    lat = 0; we_cnt = 0; we_at = 0; we_addr = 0;
    for (int k = 1; k <= 8; k++) begin
      if (o_mem_we) begin we_cnt++; we_at = k; we_addr = o_mem_addr; end
      if (o_valid) begin lat = k; break; end
      @(negedge i_clk);
    end
  endtask

  initial begin
    i_rst_n = 0; i_req = 0; i_we = 0; i_funct3 = 0; i_addr = 0; i_wdata = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h8899AABB;
    mem[6] = 32'h11223344;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    chk("rst_fault", {31'b0, o_fault}, 32'd0);
    chk("rst_rdata", o_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, o_mem_we}, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    i_rst_n = 1;

    op(0, 3'b010, 32'h10, 0);
    chk("lw_lat", lat, 2);
    chk("lw_rdata", o_rdata, 32'h8899AABB);
    chk("lw_fault", {31'b0, o_fault}, 32'd0);
    chk("lw_no_write", we_cnt, 0);
    op(0, 3'b000, 32'h11, 0);
    chk("lb_rdata", o_rdata, 32'hFFFFFFAA);
    op(0, 3'b100, 32'h11, 0);
    chk("lbu_rdata", o_rdata, 32'h000000AA);
    op(0, 3'b001, 32'h12, 0);
    chk("lh_rdata", o_rdata, 32'hFFFF8899);
    op(0, 3'b101, 32'h12, 0);
    chk("lhu_rdata", o_rdata, 32'h00008899);
    chk("lhu_lat", lat, 2);

    op(1, 3'b000, 32'h13, 32'h12345677);
    chk("sb_lat", lat, 3);
    chk("sb_we_cnt", we_cnt, 1);
    chk("sb_we_at", we_at, 2);
    chk("sb_mem_addr", we_addr, 32'h10);
    chk("sb_rdata_kept", o_rdata, 32'h00008899);
    chk("sb_fault", {31'b0, o_fault}, 32'd0);
    chk("sb_word", mem[4], 32'h7799AABB);

    op(1, 3'b010, 32'h14, 32'hCAFEF00D);
    chk("sw_lat", lat, 2);
    chk("sw_we_at", we_at, 1);
    chk("sw_word", mem[5], 32'hCAFEF00D);
    op(1, 3'b001, 32'h16, 32'h0000BEEF);
    chk("sh_lat", lat, 3);
    chk("sh_word", mem[5], 32'hBEEFF00D);

`ifdef LSU_FAULT_EN
    op(0, 3'b010, 32'h1A, 0);
    chk("lw_mis_lat", lat, 1);
    chk("lw_mis_fault", {31'b0, o_fault}, 32'd1);
    chk("lw_mis_rdata_kept", o_rdata, 32'h00008899);
    op(0, 3'b011, 32'h18, 0);
    chk("ill_f3_lat", lat, 1);
    chk("ill_f3_fault", {31'b0, o_fault}, 32'd1);
    op(1, 3'b001, 32'h19, 32'h00005678);
    chk("sh_mis_lat", lat, 1);
    chk("sh_mis_fault", {31'b0, o_fault}, 32'd1);
    chk("sh_mis_no_write", we_cnt, 0);
    chk("sh_mis_word", mem[6], 32'h11223344);
`else
    op(0, 3'b010, 32'h1A, 0);
    chk("lw_mis_lat", lat, 2);
    chk("lw_mis_fault", {31'b0, o_fault}, 32'd0);
    chk("lw_mis_rdata", o_rdata, 32'h11223344);
    op(0, 3'b011, 32'h18, 0);
    chk("ill_f3_rdata", o_rdata, 32'h11223344);
    op(1, 3'b001, 32'h19, 32'h00005678);
    chk("sh_mis_lat", lat, 3);
    chk("sh_mis_word", mem[6], 32'h11225678);
`endif

    @(negedge i_clk);
    i_req = 1; i_we = 1; i_funct3 = 3'b000; i_addr = 32'h10; i_wdata = 32'h55;
    @(posedge i_clk);
    #1;
    chk("rst_mid_busy", {31'b0, o_ready}, 32'd0);
    #1;
    i_req = 0; i_rst_n = 0;
    #1;
    chk("rst_mid_we", {31'b0, o_mem_we}, 32'd0);
    chk("rst_mid_ready", {31'b0, o_ready}, 32'd1);
    chk("rst_mid_rdata", o_rdata, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1;
    we_seen = 0; v_seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      we_seen |= o_mem_we;
      v_seen |= o_valid;
    end
    chk("rst_mid_no_write", {31'b0, we_seen}, 32'd0);
    chk("rst_mid_no_valid", {31'b0, v_seen}, 32'd0);
    chk("rst_mid_word", mem[4], 32'h7799AABB);

    @(negedge i_clk);
    i_req = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h10; i_wdata = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_funct3 = 3'b100; i_addr = 32'h14;
    chk("held_k1_ready", {31'b0, o_ready}, 32'd0);
    chk("held_k1_valid", {31'b0, o_valid}, 32'd0);
    @(negedge i_clk);
    chk("held_k2_valid", {31'b0, o_valid}, 32'd1);
    chk("held_k2_ready", {31'b0, o_ready}, 32'd0);
    chk("held_first_rdata", o_rdata, 32'h7799AABB);
    @(negedge i_clk);
    chk("held_k3_ready", {31'b0, o_ready}, 32'd1);
    chk("held_k3_valid", {31'b0, o_valid}, 32'd0);
    @(negedge i_clk);
    i_req = 0;
    chk("held_k4_valid", {31'b0, o_valid}, 32'd0);
    chk("held_k4_ready", {31'b0, o_ready}, 32'd0);
    @(negedge i_clk);
    chk("held_k5_valid", {31'b0, o_valid}, 32'd1);
    chk("held_second_rdata", o_rdata, 32'h0000000D);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
